sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_pkg.sv | 38 +++
 rtl/sdram_grant_sel.sv | 65 ++++++
 rtl/sdram_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_pkg
// Description : Shared widths, port indices and arbiter state encoding for
//               the three-port SDRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    localparam int c_NUM_PORTS   = 3;
    localparam int c_PORT_W      = 2;
    localparam int c_ADDR_W      = 24;
    localparam int c_WORD_W      = 16;
    localparam int c_BURST_WORDS = 4;
    localparam int c_BURST_W     = c_WORD_W * c_BURST_WORDS;

    localparam logic [c_PORT_W-1:0] c_PORT_LCD  = 2'd0;
    localparam logic [c_PORT_W-1:0] c_PORT_DRAW = 2'd1;
    localparam logic [c_PORT_W-1:0] c_PORT_AUX  = 2'd2;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_WAIT    = 2'd2;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;

    typedef struct packed {
        logic [c_PORT_W-1:0]  port;
        logic                 is_write;
        logic [c_ADDR_W-1:0]  addr;
        logic [c_BURST_W-1:0] data;
    } access_t;

    function automatic logic [c_NUM_PORTS-1:0] port_onehot(input logic [c_PORT_W-1:0] port);
        return c_NUM_PORTS'(1) << port;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_grant_sel.sv
`default_nettype none
// ============================================================================
// Module      : sdram_grant_sel
// Description : Winner selection: port 0 priority with starvation guard,
//               round-robin between ports 1 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_grant_sel
    import sdram_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [c_NUM_PORTS-1:0] i_req,
    input  logic                   i_grant_en,
    output logic                   o_grant_valid,
    output logic [c_PORT_W-1:0]    o_grant_port
);

    localparam int c_STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic [c_PORT_W-1:0]   r_rr_ptr;
    logic                  w_low_req;
    logic                  w_starved;
    logic                  w_pick_lcd;
    logic [c_PORT_W-1:0]   w_rr_pick;

    assign w_low_req  = i_req[c_PORT_DRAW] | i_req[c_PORT_AUX];
    assign w_starved  = w_low_req && (r_starve_cnt == c_STARVE_MAX);
    assign w_pick_lcd = i_req[c_PORT_LCD] && !w_starved;

    always_comb begin
        w_rr_pick = c_PORT_AUX;
        if (i_req[c_PORT_DRAW] && i_req[c_PORT_AUX]) begin
            w_rr_pick = r_rr_ptr;
        end else if (i_req[c_PORT_DRAW]) begin
            w_rr_pick = c_PORT_DRAW;
        end
    end

    assign o_grant_valid = |i_req;
    assign o_grant_port  = w_pick_lcd ? c_PORT_LCD : w_rr_pick;

    // Counter only advances while a low-priority port is actually waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_rr_ptr     <= c_PORT_DRAW;
        end else if (i_grant_en && o_grant_valid) begin
            if (w_pick_lcd) begin
                if (w_low_req && (r_starve_cnt != c_STARVE_MAX)) begin
                    r_starve_cnt <= r_starve_cnt + c_STARVE_W'(1);
                end
            end else begin
                r_starve_cnt <= '0;
                r_rr_ptr     <= (w_rr_pick == c_PORT_DRAW) ? c_PORT_AUX : c_PORT_DRAW;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter
// Description : Three-port burst arbiter in front of a single SDRAM
//               controller (LCD reader, draw engine, auxiliary writer).
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 1023
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [c_NUM_PORTS-1:0]             iRd_Req,
    input  logic [c_NUM_PORTS-1:0]             iWr_Req,
    input  logic [c_NUM_PORTS*c_ADDR_W-1:0]    iAddr,
    input  logic [c_NUM_PORTS*c_BURST_W-1:0]   iWr_Data,
    output logic [c_NUM_PORTS-1:0]             oRd_Done,
    output logic [c_NUM_PORTS-1:0]             oWr_Done,
    output logic [c_BURST_W-1:0]               oRd_Data,
    output logic                               oSDRAM_Rd_Req,
    output logic                               oSDRAM_Wr_Req,
    output logic [c_ADDR_W-1:0]                oSDRAM_Addr,
    output logic [c_WORD_W-1:0]                oSDRAM_Wr_Data1,
    output logic [c_WORD_W-1:0]                oSDRAM_Wr_Data2,
    output logic [c_WORD_W-1:0]                oSDRAM_Wr_Data3,
    output logic [c_WORD_W-1:0]                oSDRAM_Wr_Data4,
    input  logic                               iSDRAM_Rd_Done,
    input  logic                               iSDRAM_Wr_Done,
    input  logic [c_WORD_W-1:0]                iSDRAM_Data1,
    input  logic [c_WORD_W-1:0]                iSDRAM_Data2,
    input  logic [c_WORD_W-1:0]                iSDRAM_Data3,
    input  logic [c_WORD_W-1:0]                iSDRAM_Data4,
    output logic                               oTimeout_Err
);

    localparam int c_WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    logic [c_ADDR_W-1:0]    w_port_addr [c_NUM_PORTS];
    logic [c_BURST_W-1:0]   w_port_data [c_NUM_PORTS];
    logic [c_NUM_PORTS-1:0] w_req;
    logic                   w_grant_valid;
    logic [c_PORT_W-1:0]    w_grant_port;
    logic                   w_done_hit;
    logic                   w_timeout;

    logic [1:0]             r_state;
    access_t                r_acc;
    logic                   r_done_pend;
    logic [c_WAIT_W-1:0]    r_wait_cnt;

    for (genvar p = 0; p < c_NUM_PORTS; p++) begin : g_port
        assign w_port_addr[p] = iAddr[p*c_ADDR_W +: c_ADDR_W];
        assign w_port_data[p] = iWr_Data[p*c_BURST_W +: c_BURST_W];
    end

    assign w_req = iRd_Req | iWr_Req;

    sdram_grant_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant_sel (
        .clk           (clk),
        .rst           (rst),
        .i_req         (w_req),
        .i_grant_en    (r_state == c_ST_IDLE),
        .o_grant_valid (w_grant_valid),
        .o_grant_port  (w_grant_port)
    );

    // Only the done pulse matching the issued direction counts, once per access.
    assign w_done_hit = (r_state == c_ST_WAIT) && !r_done_pend &&
                        (r_acc.is_write ? iSDRAM_Wr_Done : iSDRAM_Rd_Done);
    assign w_timeout  = (r_state == c_ST_WAIT) && !r_done_pend && !w_done_hit &&
                        (r_wait_cnt == c_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_acc           <= '0;
            r_done_pend     <= 1'b0;
            r_wait_cnt      <= '0;
            oRd_Done        <= '0;
            oWr_Done        <= '0;
            oRd_Data        <= '0;
            oSDRAM_Rd_Req   <= 1'b0;
            oSDRAM_Wr_Req   <= 1'b0;
            oSDRAM_Addr     <= '0;
            oSDRAM_Wr_Data1 <= '0;
            oSDRAM_Wr_Data2 <= '0;
            oSDRAM_Wr_Data3 <= '0;
            oSDRAM_Wr_Data4 <= '0;
            oTimeout_Err    <= 1'b0;
        end else begin
            oRd_Done <= '0;
            oWr_Done <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_acc.port     <= w_grant_port;
                        r_acc.is_write <= iWr_Req[w_grant_port];
                        r_acc.addr     <= w_port_addr[w_grant_port];
                        r_acc.data     <= w_port_data[w_grant_port];
                        r_state        <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    oSDRAM_Addr     <= r_acc.addr;
                    oSDRAM_Wr_Data1 <= r_acc.data[0*c_WORD_W +: c_WORD_W];
                    oSDRAM_Wr_Data2 <= r_acc.data[1*c_WORD_W +: c_WORD_W];
                    oSDRAM_Wr_Data3 <= r_acc.data[2*c_WORD_W +: c_WORD_W];
                    oSDRAM_Wr_Data4 <= r_acc.data[3*c_WORD_W +: c_WORD_W];
                    oSDRAM_Wr_Req   <= r_acc.is_write;
                    oSDRAM_Rd_Req   <= !r_acc.is_write;
                    r_wait_cnt      <= '0;
                    r_done_pend     <= 1'b0;
                    r_state         <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (r_done_pend) begin
                        if (r_acc.is_write) begin
                            oWr_Done <= port_onehot(r_acc.port);
                        end else begin
                            oRd_Done <= port_onehot(r_acc.port);
                        end
                        r_done_pend <= 1'b0;
                        r_state     <= c_ST_RELEASE;
                    end else if (w_done_hit) begin
                        oSDRAM_Rd_Req <= 1'b0;
                        oSDRAM_Wr_Req <= 1'b0;
                        if (!r_acc.is_write) begin
                            oRd_Data <= {iSDRAM_Data4, iSDRAM_Data3, iSDRAM_Data2, iSDRAM_Data1};
                        end
                        r_done_pend <= 1'b1;
                    end else if (w_timeout) begin
                        oSDRAM_Rd_Req <= 1'b0;
                        oSDRAM_Wr_Req <= 1'b0;
                        oTimeout_Err  <= 1'b1;
                        r_state       <= c_ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end
                c_ST_RELEASE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_port_arbiter
// Description : Scoreboard bench for sdram_port_arbiter with a behavioural
//               SDRAM controller model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;
    import sdram_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   iRd_Req, iWr_Req;
    logic [71:0]  iAddr;
    logic [191:0] iWr_Data;
    logic [2:0]   oRd_Done, oWr_Done;
    logic [63:0]  oRd_Data;
    logic         oSDRAM_Rd_Req, oSDRAM_Wr_Req;
    logic [23:0]  oSDRAM_Addr;
    logic [15:0]  oSDRAM_Wr_Data1, oSDRAM_Wr_Data2, oSDRAM_Wr_Data3, oSDRAM_Wr_Data4;
    logic         iSDRAM_Rd_Done, iSDRAM_Wr_Done;
    logic [15:0]  iSDRAM_Data1, iSDRAM_Data2, iSDRAM_Data3, iSDRAM_Data4;
    logic         oTimeout_Err;

    typedef struct {
        logic [1:0]  port;
        logic        is_write;
        logic [23:0] addr;
        logic [63:0] data;
    } grant_t;

    typedef struct {
        logic [5:0]  done_vec;
        logic [63:0] rd_data;
        logic        is_read;
        int          due;
    } done_t;

    grant_t grant_q[$];
    done_t  done_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    int     ctl_lat = 2;
    bit     ctl_mute = 1'b0;
    bit     ctl_busy = 1'b0;
    int     ctl_cnt = 0;
    grant_t ctl_cur;
    int     rd_serial = 0;
    int     rem[3];

    sdram_port_arbiter #(.STARVE_LIMIT(8), .TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst),
        .iRd_Req(iRd_Req), .iWr_Req(iWr_Req), .iAddr(iAddr), .iWr_Data(iWr_Data),
        .oRd_Done(oRd_Done), .oWr_Done(oWr_Done), .oRd_Data(oRd_Data),
        .oSDRAM_Rd_Req(oSDRAM_Rd_Req), .oSDRAM_Wr_Req(oSDRAM_Wr_Req), .oSDRAM_Addr(oSDRAM_Addr),
        .oSDRAM_Wr_Data1(oSDRAM_Wr_Data1), .oSDRAM_Wr_Data2(oSDRAM_Wr_Data2),
        .oSDRAM_Wr_Data3(oSDRAM_Wr_Data3), .oSDRAM_Wr_Data4(oSDRAM_Wr_Data4),
        .iSDRAM_Rd_Done(iSDRAM_Rd_Done), .iSDRAM_Wr_Done(iSDRAM_Wr_Done),
        .iSDRAM_Data1(iSDRAM_Data1), .iSDRAM_Data2(iSDRAM_Data2),
        .iSDRAM_Data3(iSDRAM_Data3), .iSDRAM_Data4(iSDRAM_Data4),
        .oTimeout_Err(oTimeout_Err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One cycle: done monitor, controller model, requester auto-drop.
    task automatic step();
        logic [5:0] vec;
        logic [2:0] oh;
        logic [63:0] rdw;
        done_t d;
        @(negedge clk);
        vec = {oRd_Done, oWr_Done};
        if (done_q.size() > 0 && done_q[0].due == cyc) begin
            d = done_q.pop_front();
            check_eq("done_vec", {58'd0, vec}, {58'd0, d.done_vec});
            if (d.is_read) check_eq("rd_data", oRd_Data, d.rd_data);
        end else if (vec != 6'd0) begin
            check_eq("unexp_done", {58'd0, vec}, 64'd0);
        end

        iSDRAM_Rd_Done = 1'b0;
        iSDRAM_Wr_Done = 1'b0;
        if (!ctl_busy) begin
            if (oSDRAM_Rd_Req || oSDRAM_Wr_Req) begin
                ctl_busy = 1'b1;
                ctl_cnt  = 0;
                if (grant_q.size() == 0) begin
                    check_eq("unexp_grant", {38'd0, oSDRAM_Wr_Req, oSDRAM_Rd_Req, oSDRAM_Addr}, 64'd0);
                end else begin
                    ctl_cur = grant_q.pop_front();
                    check_eq("grant_addr", {40'd0, oSDRAM_Addr}, {40'd0, ctl_cur.addr});
                    check_eq("grant_dir", {62'd0, oSDRAM_Wr_Req, oSDRAM_Rd_Req},
                             {62'd0, ctl_cur.is_write, !ctl_cur.is_write});
                    if (ctl_cur.is_write)
                        check_eq("wr_data", {oSDRAM_Wr_Data4, oSDRAM_Wr_Data3, oSDRAM_Wr_Data2, oSDRAM_Wr_Data1},
                                 ctl_cur.data);
                end
            end
        end else begin
            ctl_cnt++;
            if (oSDRAM_Rd_Req || oSDRAM_Wr_Req)
                check_eq("addr_hold", {40'd0, oSDRAM_Addr}, {40'd0, ctl_cur.addr});
            if (ctl_cnt == ctl_lat && !ctl_mute) begin
                oh = 3'b001 << ctl_cur.port;
                rdw = '0;
                if (ctl_cur.is_write) begin
                    iSDRAM_Wr_Done = 1'b1;
                end else begin
                    rd_serial++;
                    iSDRAM_Rd_Done = 1'b1;
                    iSDRAM_Data1 = {4'h1, 12'(rd_serial)};
                    iSDRAM_Data2 = {4'h2, 12'(rd_serial)};
                    iSDRAM_Data3 = {4'h3, 12'(rd_serial)};
                    iSDRAM_Data4 = {4'h4, 12'(rd_serial)};
                    rdw = {iSDRAM_Data4, iSDRAM_Data3, iSDRAM_Data2, iSDRAM_Data1};
                end
                if (oSDRAM_Rd_Req || oSDRAM_Wr_Req) begin
                    d.done_vec = ctl_cur.is_write ? {3'b000, oh} : {oh, 3'b000};
                    d.rd_data  = rdw;
                    d.is_read  = !ctl_cur.is_write;
                    d.due      = cyc + 2;
                    done_q.push_back(d);
                end
            end
            if (ctl_cnt >= ctl_lat && !(oSDRAM_Rd_Req || oSDRAM_Wr_Req)) ctl_busy = 1'b0;
        end

        for (int p = 0; p < 3; p++) begin
            if ((oRd_Done[p] || oWr_Done[p]) && rem[p] > 0) begin
                rem[p]--;
                if (rem[p] == 0) begin
                    iRd_Req[p] = 1'b0;
                    iWr_Req[p] = 1'b0;
                end
            end
        end
    endtask

    task automatic set_port(input int p, input logic rd, input logic wr, input logic [23:0] a,
                            input logic [63:0] d, input int n);
        iAddr[24*p +: 24]    = a;
        iWr_Data[64*p +: 64] = d;
        iRd_Req[p] = rd;
        iWr_Req[p] = wr;
        rem[p]     = n;
    endtask

    task automatic expect_grant(input int p, input logic w, input logic [23:0] a, input logic [63:0] d);
        grant_t g;
        g.port = 2'(p);
        g.is_write = w;
        g.addr = a;
        g.data = d;
        grant_q.push_back(g);
    endtask

    task automatic run_idle(input int bound, input string tag);
        int n = 0;
        while ((rem[0] + rem[1] + rem[2]) != 0 && n < bound) begin
            step();
            n++;
        end
        check_eq(tag, 64'(rem[0] + rem[1] + rem[2]), 64'd0);
        repeat (4) step();
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!(oSDRAM_Rd_Req || oSDRAM_Wr_Req) && n < 20) begin
            step();
            n++;
        end
        check_eq(tag, {63'd0, oSDRAM_Rd_Req || oSDRAM_Wr_Req}, 64'd1);
    endtask

    initial begin
        int t0;
        int n;
        rst = 1'b1;
        iRd_Req = '0; iWr_Req = '0; iAddr = '0; iWr_Data = '0;
        iSDRAM_Rd_Done = 1'b0; iSDRAM_Wr_Done = 1'b0;
        iSDRAM_Data1 = '0; iSDRAM_Data2 = '0; iSDRAM_Data3 = '0; iSDRAM_Data4 = '0;
        rem[0] = 0; rem[1] = 0; rem[2] = 0;
        repeat (3) step();
        check_eq("rst_req", {62'd0, oSDRAM_Wr_Req, oSDRAM_Rd_Req}, 64'd0);
        check_eq("rst_addr", {40'd0, oSDRAM_Addr}, 64'd0);
        check_eq("rst_done", {58'd0, oRd_Done, oWr_Done}, 64'd0);
        check_eq("rst_rd_data", oRd_Data, 64'd0);
        check_eq("rst_err", {63'd0, oTimeout_Err}, 64'd0);
        rst = 1'b0;
        step();

        // Round robin: ports 1 and 2 reading together alternate 1,2,1,2.
        expect_grant(1, 1'b0, 24'd384004, '0);
        expect_grant(2, 1'b0, 24'd384008, '0);
        expect_grant(1, 1'b0, 24'd384004, '0);
        expect_grant(2, 1'b0, 24'd384008, '0);
        set_port(1, 1'b1, 1'b0, 24'd384004, '0, 2);
        set_port(2, 1'b1, 1'b0, 24'd384008, '0, 2);
        run_idle(200, "rr_complete");

        // Single port-1 write.
        expect_grant(1, 1'b1, 24'd384000, 64'h0004_0003_0002_0001);
        set_port(1, 1'b0, 1'b1, 24'd384000, 64'h0004_0003_0002_0001, 1);
        run_idle(100, "wr_complete");

        // Port 0 and port 1 together: port 0 first.
        expect_grant(0, 1'b0, 24'd100, '0);
        expect_grant(1, 1'b1, 24'd384012, 64'h1234_5678_9abc_def0);
        set_port(0, 1'b1, 1'b0, 24'd100, '0, 1);
        set_port(1, 1'b0, 1'b1, 24'd384012, 64'h1234_5678_9abc_def0, 1);
        run_idle(100, "prio_complete");

        // Starvation guard: port 1 served after exactly 8 port-0 grants.
        for (int i = 0; i < 8; i++) expect_grant(0, 1'b0, 24'd200, '0);
        expect_grant(1, 1'b0, 24'd384016, '0);
        for (int i = 0; i < 2; i++) expect_grant(0, 1'b0, 24'd200, '0);
        set_port(0, 1'b1, 1'b0, 24'd200, '0, 10);
        set_port(1, 1'b1, 1'b0, 24'd384016, '0, 1);
        run_idle(400, "starve_complete");

        // Both directions on one port: write goes first.
        expect_grant(2, 1'b1, 24'd384020, 64'hcafe_f00d_beef_0042);
        set_port(2, 1'b1, 1'b1, 24'd384020, 64'hcafe_f00d_beef_0042, 1);
        run_idle(100, "wr_first_complete");

        // Controller never answers: timeout 1023 cycles after entering WAIT.
        ctl_mute = 1'b1;
        expect_grant(2, 1'b1, 24'd384024, 64'h0d0c_0b0a_0908_0706);
        set_port(2, 1'b0, 1'b1, 24'd384024, 64'h0d0c_0b0a_0908_0706, 1);
        wait_req("to_req_seen");
        t0 = cyc;
        n = 0;
        while (!oTimeout_Err && n < 1200) begin
            step();
            n++;
        end
        check_eq("to_latency", 64'(cyc - t0), 64'd1023);
        check_eq("to_req_drop", {62'd0, oSDRAM_Wr_Req, oSDRAM_Rd_Req}, 64'd0);
        iWr_Req[2] = 1'b0;
        rem[2] = 0;
        ctl_mute = 1'b0;
        repeat (4) step();
        expect_grant(1, 1'b0, 24'd384028, '0);
        set_port(1, 1'b1, 1'b0, 24'd384028, '0, 1);
        run_idle(100, "after_to_complete");
        check_eq("to_sticky", {63'd0, oTimeout_Err}, 64'd1);

        // Reset during WAIT abandons the access; the late done is ignored.
        ctl_lat = 6;
        expect_grant(2, 1'b0, 24'd384032, '0);
        set_port(2, 1'b1, 1'b0, 24'd384032, '0, 1);
        wait_req("rst_req_seen");
        step();
        rst = 1'b1;
        iRd_Req = '0;
        iWr_Req = '0;
        rem[2] = 0;
        step();
        check_eq("rstw_req", {62'd0, oSDRAM_Wr_Req, oSDRAM_Rd_Req}, 64'd0);
        check_eq("rstw_addr", {40'd0, oSDRAM_Addr}, 64'd0);
        check_eq("rstw_err", {63'd0, oTimeout_Err}, 64'd0);
        check_eq("rstw_rd_data", oRd_Data, 64'd0);
        rst = 1'b0;
        repeat (12) step();
        ctl_lat = 2;

        check_eq("grant_q_empty", 64'(grant_q.size()), 64'd0);
        check_eq("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
